// File: rtl/tt_um_seg_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// tt_um_seg_pattern_gen_if
//   Bundles the Tiny-Tapeout style user I/O of the segment pattern generator.
//   Signals:
//     ena     : clock enable (0 freezes the generator)
//     ui_in   : [3:0] digit, [4] req_valid, [5] sweep, [6] noise_en, [7] out_ready
//     uio_in  : unused by the generator
//     uo_out  : [6:0] segments {g,f,e,d,c,b,a}, [7] out_valid
//     uio_out : [3:0] tag, [4] busy, [5] req_ready, [6] err_invalid, [7] 0
//     uio_oe  : bidirectional output enables
//   Modports: master = the driver/consumer side, slave = the generator.
// ---------------------------------------------------------------------------
interface tt_um_seg_pattern_gen_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_seg_pattern_gen.sv
// ---------------------------------------------------------------------------
// tt_um_seg_pattern_gen
//   Digit-to-7-segment stimulus generator. A digit (or a sweep of 0..SWEEP_MAX)
//   is encoded to a gfedcba pattern, optionally corrupted by NFLIP LFSR-chosen
//   segment flips, and presented under a valid/ready handshake.
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : user I/O bundle (see tt_um_seg_pattern_gen_if)
//   All outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module tt_um_seg_pattern_gen #(
  parameter int          NFLIP     = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SWEEP_MAX = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tt_um_seg_pattern_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENCODE  = 2'd1,
    S_NOISE   = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [6:0]  r_pattern;
  logic [3:0]  r_tag;
  logic        r_err;
  logic [2:0]  r_flip_cnt;
  logic [3:0]  r_sweep_cnt;
  logic [15:0] r_lfsr;
  logic        r_sweep_mode;
  logic        r_noise_en;

  logic [3:0]  w_digit;
  logic        w_req_valid;
  logic        w_sweep;
  logic        w_noise_en;
  logic        w_out_ready;

  logic [6:0]  w_rom;
  logic [2:0]  w_flip_load;
  logic [2:0]  w_flip_idx;
  logic [6:0]  w_flip_mask;
  logic [15:0] w_lfsr_next;
  logic        w_out_valid;
  logic        w_req_ready;
  logic        w_busy;

  assign w_digit     = bus.ui_in[3:0];
  assign w_req_valid = bus.ui_in[4];
  assign w_sweep     = bus.ui_in[5];
  assign w_noise_en  = bus.ui_in[6];
  assign w_out_ready = bus.ui_in[7];

  // uio_in has no function in this block
  logic w_unused;
  assign w_unused = &{1'b0, bus.uio_in};

  // Segment ROM, active-high gfedcba; non-decimal codes show a dash
  always_comb begin
    w_rom = 7'h40;
    case (r_tag)
      4'd0: w_rom = 7'h3F;
      4'd1: w_rom = 7'h06;
      4'd2: w_rom = 7'h5B;
      4'd3: w_rom = 7'h4F;
      4'd4: w_rom = 7'h66;
      4'd5: w_rom = 7'h6D;
      4'd6: w_rom = 7'h7D;
      4'd7: w_rom = 7'h07;
      4'd8: w_rom = 7'h7F;
      4'd9: w_rom = 7'h6F;
      default: w_rom = 7'h40;
    endcase
  end

  // Galois right-shift LFSR; free-running whenever ena is high
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // Only 7 segments exist, so index 7 folds onto segment a
  assign w_flip_idx  = (r_lfsr[2:0] == 3'd7) ? 3'd0 : r_lfsr[2:0];
  assign w_flip_mask = 7'd1 << w_flip_idx;

  // noise_en was latched when the request was accepted
  assign w_flip_load = r_noise_en ? 3'(NFLIP) : 3'd0;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (bus.ena) begin
      r_state <= w_state_next;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sweep || w_req_valid) w_state_next = S_ENCODE;
      end
      S_ENCODE: begin
        w_state_next = (w_flip_load != 3'd0) ? S_NOISE : S_PRESENT;
      end
      S_NOISE: begin
        if (r_flip_cnt <= 3'd1) w_state_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (w_out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---- FSM: output decode ----
  always_comb begin
    w_out_valid = 1'b0;
    w_req_ready = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
      end
      S_PRESENT: w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---- Datapath registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern    <= 7'd0;
      r_tag        <= 4'd0;
      r_err        <= 1'b0;
      r_flip_cnt   <= 3'd0;
      r_sweep_cnt  <= 4'd0;
      r_lfsr       <= LFSR_SEED;
      r_sweep_mode <= 1'b0;
      r_noise_en   <= 1'b0;
    end else if (bus.ena) begin
      r_lfsr <= w_lfsr_next;
      case (r_state)
        S_IDLE: begin
          // Sweep takes priority and ignores req_valid
          if (w_sweep) begin
            r_tag        <= r_sweep_cnt;
            r_sweep_mode <= 1'b1;
            r_noise_en   <= w_noise_en;
          end else if (w_req_valid) begin
            r_tag        <= w_digit;
            r_sweep_mode <= 1'b0;
            r_noise_en   <= w_noise_en;
          end
        end
        S_ENCODE: begin
          r_pattern  <= w_rom;
          r_err      <= (r_tag > 4'd9);
          r_flip_cnt <= w_flip_load;
        end
        S_NOISE: begin
          r_pattern  <= r_pattern ^ w_flip_mask;
          r_flip_cnt <= r_flip_cnt - 3'd1;
        end
        S_PRESENT: begin
          if (w_out_ready && r_sweep_mode) begin
            r_sweep_cnt <= (r_sweep_cnt == 4'(SWEEP_MAX)) ? 4'd0 : r_sweep_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.uo_out  = {w_out_valid, r_pattern};
  assign bus.uio_out = {1'b0, r_err, w_req_ready, w_busy, r_tag};
  assign bus.uio_oe  = 8'h7F;

endmodule
